bt_uart_tx: RTL and testbench

UART transmitter for the Bluetooth serial link: it accepts one byte at a time over a valid/ready handshake and shifts it out on a single TX line as an 8N1 frame (1 start, 8 data LSB-first, 1 stop). It is the transmit-side counterpart of the Bluetooth receive path and shares its bit-rate timebase. It sits between game/control logic and the Bluetooth module's RXD pin.

---
 rtl/bt_uart_pkg.sv | 19 +
 rtl/bt_baud_cnt.sv | 44 ++++
 rtl/bt_uart_tx.sv | 109 ++++++++++
 tb/tb_bt_uart_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth serial link: frame states and the
// baud constants used by both the transmit and receive dividers.
package bt_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS        = 8;
    localparam int IDX_W            = $clog2(DATA_BITS);
    localparam int CLKS_PER_BIT_DEF = 10416;
    localparam int CNT_W_DEF        = 20;

    localparam logic [IDX_W-1:0] LAST_BIT_IDX = IDX_W'(DATA_BITS - 1);

endpackage

// File: rtl/bt_baud_cnt.sv
// Bit-period timebase: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each period; parked at zero whenever disabled or cleared.
module bt_baud_cnt
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_end = (count_q == LAST_CNT);

    // Next count: wrap at the end of a period, hold at zero when idle.
    always_comb begin
        count_d = count_q;
        if (clr || !en) begin
            count_d = '0;
        end else if (bit_end) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter feeding the Bluetooth module's RXD pin; one byte per
// valid/ready handshake, shifted out LSB first from a registered line.
module bt_uart_tx
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    tx_state_e              state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic                   tx_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   bit_end_s;
    logic                   accept_s;
    logic                   cnt_en_s;

    assign accept_s = (state_q == IDLE) && tx_valid;
    assign cnt_en_s = (state_q != IDLE);

    bt_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept_s),
        .en      (cnt_en_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencer; the line level for the coming cycle is decided here so tx never sees inputs combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_q   <= tx_data;
                        bit_idx_q <= '0;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        tx_q      <= 1'b1;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_q == LAST_BIT_IDX) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            // shift_q[1] is the bit that lands in position 0 after this shift
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = (state_q == STOP) && bit_end_s;

endmodule

// File: tb/tb_bt_uart_tx.sv
// Self-checking bench for bt_uart_tx at CLKS_PER_BIT=4: a frame-position
// reference model, a mid-bit sampling UART decoder, vector table and sequences.
module tb_bt_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    bt_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(20)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: ph = cycles since the start bit began, -1 when idle.
    int         ph = -1;
    logic [7:0] mb = 8'h00;
    logic [7:0] exp_q[$];

    // Decoder state.
    int         dcnt = -1;
    logic [7:0] dbyte = 8'h00;
    logic [7:0] dec_q[$];
    int         done_cnt = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] dat;
        logic       e_tx;
        logic       e_rdy;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[10];

    function automatic logic model_tx();
        int k;
        if (ph < 0) return 1'b1;
        k = ph / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return mb[k-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            ph = -1;
        end else if (ph < 0) begin
            if (tx_valid) begin
                mb = tx_data;
                ph = 0;
            end
        end else begin
            ph++;
            if (ph == 9*C + C/2) exp_q.push_back(mb);
            if (ph == 10*C) ph = -1;
        end
        @(negedge clk);
        check("model_tx", tx, model_tx());
        check("model_ready", tx_ready, (ph < 0));
        check("model_busy", tx_busy, (ph >= 0));
        check("model_done", tx_done, (ph == 10*C - 1));
        if (tx_done === 1'b1) done_cnt++;
        if (reset) begin
            dcnt = -1;
        end else if (dcnt < 0) begin
            if (tx === 1'b0) dcnt = 0;
        end else begin
            dcnt++;
            if ((dcnt % C) == C/2 && (dcnt / C) >= 1 && (dcnt / C) <= 8)
                dbyte[dcnt/C - 1] = tx;
            if (dcnt == 9*C + C/2) begin
                check("stop_bit", tx, 1);
                dec_q.push_back(dbyte);
                dcnt = -1;
            end
        end
    endtask

    task automatic idle(input int n);
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset, reset-beats-valid, idle, then accept of 0x3C into start and bit 0.
        for (int i = 0; i < 10; i++) begin
            reset    = tbl[i].rst;
            tx_valid = tbl[i].vld;
            tx_data  = tbl[i].dat;
            step();
            check("vec_tx", tx, tbl[i].e_tx);
            check("vec_ready", tx_ready, tbl[i].e_rdy);
            check("vec_busy", tx_busy, tbl[i].e_busy);
            check("vec_done", tx_done, tbl[i].e_done);
        end
        idle(40);
        check("vec_decode_cnt", dec_q.size(), 1);

        // Twenty idle cycles with no tx_done.
        done_cnt = 0;
        idle(20);
        check("idle_no_done", done_cnt, 0);

        // 0x55: line alternates every bit, done only on cycle 40.
        send(8'h55);
        for (int i = 0; i < 10*C; i++) begin
            check("p55_tx", tx, (i / C) % 2);
            check("p55_done", tx_done, (i == 10*C - 1));
            step();
        end
        check("p55_ready_after", tx_ready, 1);
        check("p55_decode", dec_q[dec_q.size()-1], 8'h55);

        // Back-to-back with tx_valid held: second accept after one idle cycle.
        idle(3);
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        step();
        tx_data  = 8'h0F;
        for (int i = 0; i < 10*C - 1; i++) step();
        check("b2b_done_edge", tx_done, 1);
        step();
        check("b2b_gap_tx", tx, 1);
        check("b2b_gap_ready", tx_ready, 1);
        step();
        tx_valid = 1'b0;
        check("b2b_second_start", tx, 0);
        idle(10*C + 4);
        check("b2b_first", dec_q[dec_q.size()-2], 8'hA3);
        check("b2b_second", dec_q[dec_q.size()-1], 8'h0F);

        // Offers during a frame are ignored; tx_data changes have no effect.
        begin
            int n0;
            n0 = dec_q.size();
            send(8'h96);
            tx_valid = 1'b1;
            tx_data  = 8'hFF;
            for (int i = 0; i < 12; i++) step();
            tx_data  = 8'h00;
            for (int i = 0; i < 12; i++) step();
            tx_valid = 1'b0;
            idle(20);
            check("ignore_count", dec_q.size(), n0 + 1);
            check("ignore_byte", dec_q[dec_q.size()-1], 8'h96);
        end

        // Reset during data bit 3 of 0x00, then 0x81 goes out cleanly.
        done_cnt = 0;
        send(8'h00);
        for (int i = 0; i < 4*C + 1; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        idle(10*C);
        check("rst_no_done", done_cnt, 0);
        send(8'h81);
        idle(10*C + 2);
        check("rst_then_81", dec_q[dec_q.size()-1], 8'h81);

        // Random traffic with occasional resets against the model.
        for (int i = 0; i < 800; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        idle(10*C + 4);

        check("decode_count", dec_q.size(), exp_q.size());
        for (int i = 0; i < dec_q.size() && i < exp_q.size(); i++)
            check("decode_byte", dec_q[i], exp_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
